// File: rtl/l2_cache_wb.sv
// Set-associative write-back, write-allocate L2 cache with true-LRU replacement.
// Whole-block transfers on both the CPU side and the memory side.
module l2_cache_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          l2_cache_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_in,
    input  logic                           l2_cache_read,
    input  logic                           l2_cache_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_out,
    output logic                           l2_cache_ready,
    output logic                           l2_hit,
    output logic                           l2_cache_busy,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
    output logic                           mem_read,
    output logic                           mem_write,
    input  logic                           mem_ready
);
    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND} state_t;
    state_t state_reg, state_next;

    logic [TAG_W-1:0] req_tag_reg;
    logic [IDX_W-1:0] req_idx_reg;
    logic [BLK_W-1:0] wdata_reg;
    logic             is_write_reg;
    logic             hit_reg;
    logic [WAY_W-1:0] victim_way_reg;
    logic [TAG_W-1:0] victim_tag_reg;
    logic [BLK_W-1:0] data_out_reg;
    logic [BLK_W-1:0] mem_data_out_reg;

    logic [TAG_W-1:0]    tag_reg   [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_reg   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_reg [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_reg [NUM_SETS];
    logic [BLK_W-1:0]    data_mem  [NUM_SETS*NUM_WAYS];

    logic [NUM_WAYS-1:0] way_hit;
    logic [NUM_WAYS-1:0] way_oldest;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim_way;
    logic                victim_dirty;

    logic                wr_en;
    logic                wr_fill;
    logic [WAY_W-1:0]    wr_way;
    logic                touch;
    logic [WAY_W-1:0]    touch_way;

    logic unused_offset;
    assign unused_offset = ^l2_cache_addr[OFF_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_hit[gi]    = valid_reg[req_idx_reg][gi] && (tag_reg[req_idx_reg][gi] == req_tag_reg);
            assign way_oldest[gi] = (age_reg[req_idx_reg][gi] == WAY_W'(NUM_WAYS - 1));
        end
    endgenerate

    assign hit = |way_hit;

    // Victim: lowest-index invalid way first, otherwise the LRU way.
    always_comb begin
        hit_way    = '0;
        victim_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (way_hit[i]) hit_way = WAY_W'(i);
        end
        if (&valid_reg[req_idx_reg]) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (way_oldest[i]) victim_way = WAY_W'(i);
            end
        end else begin
            for (int i = NUM_WAYS - 1; i >= 0; i--) begin
                if (!valid_reg[req_idx_reg][i]) victim_way = WAY_W'(i);
            end
        end
        victim_dirty = valid_reg[req_idx_reg][victim_way] && dirty_reg[req_idx_reg][victim_way];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        wr_fill    = 1'b0;
        wr_way     = '0;
        touch      = 1'b0;
        touch_way  = '0;
        case (state_reg)
            IDLE: begin
                if (l2_cache_read || l2_cache_write) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    state_next = RESPOND;
                    touch      = 1'b1;
                    touch_way  = hit_way;
                    wr_en      = is_write_reg;
                    wr_way     = hit_way;
                end else if (victim_dirty) begin
                    state_next = WRITEBACK;
                end else if (is_write_reg) begin
                    state_next = RESPOND;
                    wr_en      = 1'b1;
                    wr_way     = victim_way;
                    touch      = 1'b1;
                    touch_way  = victim_way;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    if (is_write_reg) begin
                        state_next = RESPOND;
                        wr_en      = 1'b1;
                        wr_way     = victim_way_reg;
                        touch      = 1'b1;
                        touch_way  = victim_way_reg;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_next = RESPOND;
                    wr_en      = 1'b1;
                    wr_fill    = 1'b1;
                    wr_way     = victim_way_reg;
                    touch      = 1'b1;
                    touch_way  = victim_way_reg;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Block storage has no reset; validity lives in valid_reg.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            data_mem[{req_idx_reg, wr_way}] <= wr_fill ? mem_data_in : wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_reg[s][w] <= WAY_W'(w);
            end
            req_tag_reg      <= '0;
            req_idx_reg      <= '0;
            wdata_reg        <= '0;
            is_write_reg     <= 1'b0;
            hit_reg          <= 1'b0;
            victim_way_reg   <= '0;
            victim_tag_reg   <= '0;
            data_out_reg     <= '0;
            mem_data_out_reg <= '0;
        end else begin
            if (state_reg == IDLE && (l2_cache_read || l2_cache_write)) begin
                req_tag_reg  <= l2_cache_addr[ADDR_WIDTH-1 -: TAG_W];
                req_idx_reg  <= l2_cache_addr[OFF_W +: IDX_W];
                wdata_reg    <= l2_cache_data_in;
                is_write_reg <= l2_cache_write;
            end
            if (state_reg == LOOKUP) begin
                hit_reg        <= hit;
                victim_way_reg <= victim_way;
                victim_tag_reg <= tag_reg[req_idx_reg][victim_way];
                if (hit && !is_write_reg) data_out_reg <= data_mem[{req_idx_reg, hit_way}];
                if (!hit && victim_dirty) mem_data_out_reg <= data_mem[{req_idx_reg, victim_way}];
            end
            if (state_reg == ALLOCATE && mem_ready) data_out_reg <= mem_data_in;
            if (wr_en) begin
                tag_reg[req_idx_reg][wr_way]   <= req_tag_reg;
                valid_reg[req_idx_reg][wr_way] <= 1'b1;
                dirty_reg[req_idx_reg][wr_way] <= !wr_fill;
            end
            if (touch) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_reg[req_idx_reg][w] <= '0;
                    else if (age_reg[req_idx_reg][w] < age_reg[req_idx_reg][touch_way])
                        age_reg[req_idx_reg][w] <= age_reg[req_idx_reg][w] + 1'b1;
                end
            end
        end
    end

    assign l2_cache_data_out = data_out_reg;
    assign mem_data_out      = mem_data_out_reg;
    assign l2_cache_ready    = (state_reg == RESPOND);
    assign l2_hit            = (state_reg == RESPOND) && hit_reg;
    assign l2_cache_busy     = (state_reg != IDLE);
    assign mem_write         = (state_reg == WRITEBACK);
    assign mem_read          = (state_reg == ALLOCATE);

    always_comb begin
        mem_addr = '0;
        if (state_reg == WRITEBACK)
            mem_addr = {victim_tag_reg, req_idx_reg, {OFF_W{1'b0}}};
        else if (state_reg == ALLOCATE)
            mem_addr = {req_tag_reg, req_idx_reg, {OFF_W{1'b0}}};
    end
endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed testbench for l2_cache_wb: hit/miss latency, eviction writeback,
// write-allocate install, request arbitration and mid-transaction reset.
module tb_l2_cache_wb;
    localparam int BLK_W = 512;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      l2_cache_addr;
    logic [BLK_W-1:0] l2_cache_data_in;
    logic             l2_cache_read;
    logic             l2_cache_write;
    logic [BLK_W-1:0] l2_cache_data_out;
    logic             l2_cache_ready;
    logic             l2_hit;
    logic             l2_cache_busy;
    logic [31:0]      mem_addr;
    logic [BLK_W-1:0] mem_data_out;
    logic [BLK_W-1:0] mem_data_in;
    logic             mem_read;
    logic             mem_write;
    logic             mem_ready;

    int vectors = 0;
    int errors  = 0;

    // Observations of the last transaction
    int               r_ready_cyc, r_rd_cyc, r_wb_cyc;
    logic             r_hit, r_rd, r_wb, r_both, r_ready_after;
    logic [31:0]      r_rd_addr, r_wb_addr, r_wb_word0;
    logic [BLK_W-1:0] r_block;

    l2_cache_wb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l2_cache_addr     (l2_cache_addr),
        .l2_cache_data_in  (l2_cache_data_in),
        .l2_cache_read     (l2_cache_read),
        .l2_cache_write    (l2_cache_write),
        .l2_cache_data_out (l2_cache_data_out),
        .l2_cache_ready    (l2_cache_ready),
        .l2_hit            (l2_hit),
        .l2_cache_busy     (l2_cache_busy),
        .mem_addr          (mem_addr),
        .mem_data_out      (mem_data_out),
        .mem_data_in       (mem_data_in),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_ready         (mem_ready)
    );

    always #5 clk = ~clk;

    // Issue one request and act as memory: mem_ready pulses after `delay`
    // cycles of each transfer. Cycle 1 is the cycle after the accepting edge.
    task automatic run_txn(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wbase, input logic winc,
                           input logic [31:0] fill, input int delay, input logic poke);
        int cnt = 0;
        for (int i = 0; i < 16; i++) l2_cache_data_in[i*32 +: 32] = wbase + (winc ? i : 0);
        mem_data_in = {16{fill}};
        r_ready_cyc = 0; r_rd_cyc = 0; r_wb_cyc = 0;
        r_hit = 1'bx; r_rd = 0; r_wb = 0; r_both = 0;
        r_rd_addr = '0; r_wb_addr = '0; r_wb_word0 = '0; r_block = '0;
        @(negedge clk);
        l2_cache_addr  = addr;
        l2_cache_read  = rd;
        l2_cache_write = wr;
        @(posedge clk);
        @(negedge clk);
        l2_cache_read  = 1'b0;
        l2_cache_write = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_ready) mem_ready = 1'b0;
            if (poke && c == 2) begin
                l2_cache_read = 1'b1;
                l2_cache_addr = 32'h200;
            end else if (poke && c == 3) begin
                l2_cache_read = 1'b0;
            end
            if (mem_read && mem_write) r_both = 1'b1;
            if (mem_write && !r_wb) begin
                r_wb = 1'b1; r_wb_addr = mem_addr; r_wb_word0 = mem_data_out[31:0]; r_wb_cyc = c;
            end
            if (mem_read && !r_rd) begin
                r_rd = 1'b1; r_rd_addr = mem_addr; r_rd_cyc = c;
            end
            if (mem_read || mem_write) begin
                cnt++;
                if (cnt >= delay) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                end
            end
            if (l2_cache_ready) begin
                r_ready_cyc = c;
                r_hit       = l2_hit;
                r_block     = l2_cache_data_out;
                break;
            end
        end
        l2_cache_read = 1'b0;
        @(negedge clk);
        mem_ready     = 1'b0;
        r_ready_after = l2_cache_ready;
        $display("txn addr=%h rd=%0b wr=%0b ready_cycle=%0d hit=%0b memrd=%0b(%h) memwr=%0b(%h) word0=%h",
                 addr, rd, wr, r_ready_cyc, r_hit, r_rd, r_rd_addr, r_wb, r_wb_addr, r_block[31:0]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        l2_cache_addr = '0; l2_cache_data_in = '0; l2_cache_read = 0; l2_cache_write = 0;
        mem_data_in = '0; mem_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (l2_cache_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", l2_cache_ready); end
        vectors++; if (l2_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", l2_hit); end
        vectors++; if (l2_cache_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", l2_cache_busy); end
        vectors++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_memctl: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
        vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (l2_cache_data_out !== '0 || mem_data_out !== '0) begin errors++; $display("FAIL reset_data: got out=%h wb=%h want 0", l2_cache_data_out[31:0], mem_data_out[31:0]); end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_read_miss;
        run_txn(32'h100, 1, 0, 32'h0, 0, 32'hDEADBEEF, 3, 0);
        vectors++; if (r_ready_cyc !== 5) begin errors++; $display("FAIL miss_latency: got %0d want 5", r_ready_cyc); end
        vectors++; if (r_hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", r_hit); end
        vectors++; if (r_rd !== 1'b1 || r_rd_addr !== 32'h100 || r_rd_cyc !== 2) begin errors++; $display("FAIL miss_memread: got rd=%b addr=%h cyc=%0d want 1 00000100 2", r_rd, r_rd_addr, r_rd_cyc); end
        vectors++; if (r_wb !== 1'b0) begin errors++; $display("FAIL miss_no_wb: got %b want 0", r_wb); end
        vectors++; if (r_block[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data: got %h want deadbeef", r_block[31:0]); end
        vectors++; if (r_ready_after !== 1'b0) begin errors++; $display("FAIL miss_ready_pulse: got %b want 0", r_ready_after); end
    endtask

    task automatic test_read_hit;
        run_txn(32'h100, 1, 0, 32'h0, 0, 32'h0, 1, 0);
        vectors++; if (r_ready_cyc !== 2) begin errors++; $display("FAIL hit_latency: got %0d want 2", r_ready_cyc); end
        vectors++; if (r_hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b want 1", r_hit); end
        vectors++; if (r_rd !== 1'b0 || r_wb !== 1'b0) begin errors++; $display("FAIL hit_no_traffic: got rd=%b wr=%b want 0 0", r_rd, r_wb); end
        vectors++; if (r_block[31:0] !== 32'hDEADBEEF || r_block[511:480] !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data: got %h/%h want deadbeef", r_block[31:0], r_block[511:480]); end
    endtask

    task automatic test_evict_writeback;
        run_txn(32'h100, 0, 1, 32'hA5A5A5A5, 0, 32'h0, 1, 0);
        vectors++; if (r_ready_cyc !== 2 || r_hit !== 1'b1 || r_rd || r_wb) begin errors++; $display("FAIL whit: got cyc=%0d hit=%b rd=%b wr=%b want 2 1 0 0", r_ready_cyc, r_hit, r_rd, r_wb); end
        run_txn(32'h200, 1, 0, 32'h0, 0, 32'h22222222, 1, 0);
        vectors++; if (r_ready_cyc !== 3 || r_hit !== 1'b0 || r_wb !== 1'b0) begin errors++; $display("FAIL fill_200: got cyc=%0d hit=%b wb=%b want 3 0 0", r_ready_cyc, r_hit, r_wb); end
        run_txn(32'h300, 1, 0, 32'h0, 0, 32'h33333333, 1, 0);
        vectors++; if (r_ready_cyc !== 3 || r_wb !== 1'b0) begin errors++; $display("FAIL fill_300: got cyc=%0d wb=%b want 3 0", r_ready_cyc, r_wb); end
        run_txn(32'h400, 1, 0, 32'h0, 0, 32'h44444444, 1, 0);
        vectors++; if (r_ready_cyc !== 3 || r_wb !== 1'b0) begin errors++; $display("FAIL fill_400: got cyc=%0d wb=%b want 3 0", r_ready_cyc, r_wb); end
        run_txn(32'h500, 1, 0, 32'h0, 0, 32'h55555555, 2, 0);
        vectors++; if (r_wb !== 1'b1 || r_wb_addr !== 32'h100 || r_wb_word0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL evict_wb: got wr=%b addr=%h word0=%h want 1 00000100 a5a5a5a5", r_wb, r_wb_addr, r_wb_word0); end
        vectors++; if (r_rd !== 1'b1 || r_rd_addr !== 32'h500 || r_wb_cyc !== 2 || r_rd_cyc !== 4) begin errors++; $display("FAIL evict_fill: got rd=%b addr=%h wbcyc=%0d rdcyc=%0d want 1 00000500 2 4", r_rd, r_rd_addr, r_wb_cyc, r_rd_cyc); end
        vectors++; if (r_ready_cyc !== 6 || r_hit !== 1'b0 || r_block[31:0] !== 32'h55555555) begin errors++; $display("FAIL evict_resp: got cyc=%0d hit=%b word0=%h want 6 0 55555555", r_ready_cyc, r_hit, r_block[31:0]); end
        vectors++; if (r_both !== 1'b0) begin errors++; $display("FAIL evict_exclusive: got %b want 0", r_both); end
        run_txn(32'h200, 1, 0, 32'h0, 0, 32'h0, 1, 0);
        vectors++; if (r_hit !== 1'b1 || r_block[31:0] !== 32'h22222222) begin errors++; $display("FAIL lru_keep_200: got hit=%b word0=%h want 1 22222222", r_hit, r_block[31:0]); end
    endtask

    task automatic test_write_miss_install;
        run_txn(32'h610, 0, 1, 32'h61000000, 1, 32'h0, 1, 0);
        vectors++; if (r_ready_cyc !== 2 || r_hit !== 1'b0) begin errors++; $display("FAIL wmiss_resp: got cyc=%0d hit=%b want 2 0", r_ready_cyc, r_hit); end
        vectors++; if (r_rd !== 1'b0 || r_wb !== 1'b0) begin errors++; $display("FAIL wmiss_no_traffic: got rd=%b wr=%b want 0 0", r_rd, r_wb); end
        run_txn(32'h610, 1, 0, 32'h0, 0, 32'h0, 1, 0);
        vectors++; if (r_hit !== 1'b1 || r_ready_cyc !== 2) begin errors++; $display("FAIL wmiss_reread: got hit=%b cyc=%0d want 1 2", r_hit, r_ready_cyc); end
        vectors++; if (r_block[31:0] !== 32'h61000000 || r_block[191:160] !== 32'h61000005 || r_block[511:480] !== 32'h6100000F) begin errors++; $display("FAIL wmiss_data: got %h %h %h want 61000000 61000005 6100000f", r_block[31:0], r_block[191:160], r_block[511:480]); end
    endtask

    task automatic test_rw_and_busy;
        int extra = 0;
        logic stuck = 0;
        // 0x100 was evicted; LRU victim in set 0 is clean, so the write installs directly
        run_txn(32'h100, 1, 1, 32'h11111111, 0, 32'h0, 1, 0);
        vectors++; if (r_ready_cyc !== 2 || r_rd !== 1'b0 || r_wb !== 1'b0) begin errors++; $display("FAIL rw_write_wins: got cyc=%0d rd=%b wr=%b want 2 0 0", r_ready_cyc, r_rd, r_wb); end
        run_txn(32'h100, 1, 0, 32'h0, 0, 32'h0, 1, 0);
        vectors++; if (r_hit !== 1'b1 || r_block[31:0] !== 32'h11111111) begin errors++; $display("FAIL rw_readback: got hit=%b word0=%h want 1 11111111", r_hit, r_block[31:0]); end
        run_txn(32'h700, 1, 0, 32'h0, 0, 32'h77777777, 2, 1);
        vectors++; if (r_ready_cyc !== 4 || r_block[31:0] !== 32'h77777777) begin errors++; $display("FAIL busy_txn: got cyc=%0d word0=%h want 4 77777777", r_ready_cyc, r_block[31:0]); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (l2_cache_ready) extra++;
            if (l2_cache_busy) stuck = 1'b1;
        end
        vectors++; if (extra !== 0 || stuck !== 1'b0) begin errors++; $display("FAIL busy_drop: got extra_ready=%0d busy=%b want 0 0", extra, stuck); end
    endtask

    task automatic test_reset_writeback;
        logic seen = 0;
        test_reset;
        run_txn(32'h100, 0, 1, 32'hCAFEF00D, 0, 32'h0, 1, 0);
        run_txn(32'h200, 1, 0, 32'h0, 0, 32'h22222222, 1, 0);
        run_txn(32'h300, 1, 0, 32'h0, 0, 32'h33333333, 1, 0);
        run_txn(32'h400, 1, 0, 32'h0, 0, 32'h44444444, 1, 0);
        vectors++; if (r_block[31:0] !== 32'h44444444) begin errors++; $display("FAIL rst_setup: got %h want 44444444", r_block[31:0]); end
        @(negedge clk);
        l2_cache_addr = 32'h500;
        l2_cache_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        l2_cache_read = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mem_write) seen = 1'b1;
            else @(negedge clk);
        end
        vectors++; if (seen !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL rst_wb_entry: got seen=%b addr=%h want 1 00000100", seen, mem_addr); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (mem_write !== 1'b0 || l2_cache_busy !== 1'b0 || l2_cache_ready !== 1'b0) begin errors++; $display("FAIL rst_abort: got wr=%b busy=%b ready=%b want 0 0 0", mem_write, l2_cache_busy, l2_cache_ready); end
        vectors++; if (l2_cache_data_out !== '0) begin errors++; $display("FAIL rst_dataout: got %h want 0", l2_cache_data_out[31:0]); end
        $display("txn reset during writeback");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h100, 1, 0, 32'h0, 0, 32'h0BADF00D, 1, 0);
        vectors++; if (r_hit !== 1'b0 || r_rd !== 1'b1 || r_wb !== 1'b0 || r_ready_cyc !== 3) begin errors++; $display("FAIL rst_remiss: got hit=%b rd=%b wr=%b cyc=%0d want 0 1 0 3", r_hit, r_rd, r_wb, r_ready_cyc); end
        vectors++; if (r_block[31:0] !== 32'h0BADF00D) begin errors++; $display("FAIL rst_remiss_data: got %h want 0badf00d", r_block[31:0]); end
    endtask

    initial begin
        test_reset;
        test_read_miss;
        test_read_hit;
        test_evict_writeback;
        test_write_miss_install;
        test_rw_and_busy;
        test_reset_writeback;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
